// File: rtl/dominos_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dominos_input_pkg
//  Purpose  : Shared types, joystick bit indices and helpers for the Dominos
//             cabinet input conditioner.
//  Contents : coin_state_t  - per-player coin FSM state
//             JOY_*         - bit positions inside a MiSTer joystick word
//             DB_*          - slot positions inside the debouncer vector
//             dir_cancel()  - opposite-direction cancel on a {U,D,L,R} nibble
//  Revision : 1.0  initial release
// ============================================================================
package dominos_input_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } coin_state_t;

  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_COIN = 4;
  localparam int JOY_ST1  = 5;
  localparam int JOY_ST2  = 6;

  // Layout of the 12 debounced signals: two {U,D,L,R} nibbles, two coins,
  // then the merged start buttons.
  localparam int NUM_DB    = 12;
  localparam int DB_P1_DIR = 0;
  localparam int DB_P2_DIR = 4;
  localparam int DB_COIN1  = 8;
  localparam int DB_COIN2  = 9;
  localparam int DB_ST1    = 10;
  localparam int DB_ST2    = 11;

  // Input and result are active-high {U,D,L,R}; a pair pressed together
  // cancels to "neither pressed".
  function automatic logic [3:0] dir_cancel(input logic [3:0] udlr);
    logic [3:0] res;
    res = udlr;
    if (udlr[3] && udlr[2]) res[3:2] = 2'b00;
    if (udlr[1] && udlr[0]) res[1:0] = 2'b00;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dominos_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : dominos_debounce
//  Purpose  : Single-bit tick-based debouncer. The accepted level follows the
//             raw level once it has differed for DEBOUNCE_MS consecutive ticks.
//  Ports    : clk_i     system clock
//             rst_ni    asynchronous reset, active low (stable = released)
//             tick_i    one-cycle timebase strobe
//             raw_i     registered raw level
//             stable_o  debounced level
//  Revision : 1.0  initial release
// ============================================================================
module dominos_debounce #(
  parameter int DEBOUNCE_MS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o
);

  logic stable_q;
  assign stable_o = stable_q;

  if (DEBOUNCE_MS == 0) begin : g_bypass
    logic tick_unused;
    assign tick_unused = tick_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stable_q <= 1'b0;
      else         stable_q <= raw_i;
    end
  end else begin : g_filter
    localparam int CNT_W = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_d;

    // The tick that would take the count to DEBOUNCE_MS accepts the new level
    // directly, so the accepted level only ever changes on a tick edge.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (raw_i == stable_q) begin
        cnt_d = '0;
      end else if (tick_i) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = raw_i;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dominos_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : dominos_input_cond
//  Purpose  : Conditions MiSTer joystick words into the active-low cabinet
//             inputs of the Dominos core: debounce, opposite-direction cancel,
//             fixed-width coin pulses with lockout, start-button merge.
//  Ports    : Clk_I       12 MHz system clock
//             Reset_I     asynchronous reset, active low
//             Hold_I      1 = ROM download, all game inputs forced inactive
//             Joy0_I/1_I  joystick words [0]R [1]L [2]D [3]U [4]coin [5]st1 [6]st2
//             Dir1_O/2_O  {Up,Down,Left,Right}, active low
//             Coin1_O/2_O coin mech pulses, active low
//             Start1_O/2_O merged start buttons, active low
//             Coin_Cnt_O  accepted-coin count
//  Config   : DOMINOS_COIN_COUNTER_EN - builds the saturating coin counter;
//             otherwise Coin_Cnt_O is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module dominos_input_cond
  import dominos_input_pkg::*;
#(
  parameter int TICK_DIV      = 12000,
  parameter int DEBOUNCE_MS   = 4,
  parameter int COIN_PULSE_MS = 40,
  parameter int COIN_GAP_MS   = 60
) (
  input  logic        Clk_I,
  input  logic        Reset_I,
  input  logic        Hold_I,
  input  logic [15:0] Joy0_I,
  input  logic [15:0] Joy1_I,
  output logic [3:0]  Dir1_O,
  output logic [3:0]  Dir2_O,
  output logic        Coin1_O,
  output logic        Coin2_O,
  output logic        Start1_O,
  output logic        Start2_O,
  output logic [7:0]  Coin_Cnt_O
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam int CT_MAX = (COIN_PULSE_MS > COIN_GAP_MS) ? COIN_PULSE_MS : COIN_GAP_MS;
  localparam int CT_W   = $clog2(CT_MAX + 1);
  localparam logic [CT_W-1:0] PULSE_LAST = CT_W'(COIN_PULSE_MS);
  localparam logic [CT_W-1:0] GAP_LAST   = CT_W'(COIN_GAP_MS);

  // ---------------- timebase and input register ----------------
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [6:0]       joy0_q, joy1_q;
  logic [17:0]      joy_unused;

  assign tick       = (pre_q == PRE_LAST);
  assign pre_d      = tick ? '0 : pre_q + PRE_W'(1);
  assign joy_unused = {Joy0_I[15:7], Joy1_I[15:7]};

  always_ff @(posedge Clk_I or negedge Reset_I) begin
    if (!Reset_I) begin
      pre_q  <= '0;
      joy0_q <= '0;
      joy1_q <= '0;
    end else begin
      pre_q  <= pre_d;
      joy0_q <= Joy0_I[6:0];
      joy1_q <= Joy1_I[6:0];
    end
  end

  // ---------------- debouncers ----------------
  logic [NUM_DB-1:0] raw, db;

  assign raw = {joy0_q[JOY_ST2] | joy1_q[JOY_ST2],
                joy0_q[JOY_ST1] | joy1_q[JOY_ST1],
                joy1_q[JOY_COIN], joy0_q[JOY_COIN],
                joy1_q[JOY_U], joy1_q[JOY_D], joy1_q[JOY_L], joy1_q[JOY_R],
                joy0_q[JOY_U], joy0_q[JOY_D], joy0_q[JOY_L], joy0_q[JOY_R]};

  for (genvar gi = 0; gi < NUM_DB; gi++) begin : g_db
    dominos_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk_i    (Clk_I),
      .rst_ni   (Reset_I),
      .tick_i   (tick),
      .raw_i    (raw[gi]),
      .stable_o (db[gi])
    );
  end

  // ---------------- directions and starts ----------------
  logic [3:0] dir1_q, dir1_d, dir2_q, dir2_d;
  logic       st1_q, st1_d, st2_q, st2_d;

  always_comb begin
    dir1_d = ~dir_cancel(db[DB_P1_DIR +: 4]);
    dir2_d = ~dir_cancel(db[DB_P2_DIR +: 4]);
    st1_d  = ~db[DB_ST1];
    st2_d  = ~db[DB_ST2];
    if (Hold_I) begin
      dir1_d = 4'hF;
      dir2_d = 4'hF;
      st1_d  = 1'b1;
      st2_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk_I or negedge Reset_I) begin
    if (!Reset_I) begin
      dir1_q <= 4'hF;
      dir2_q <= 4'hF;
      st1_q  <= 1'b1;
      st2_q  <= 1'b1;
    end else begin
      dir1_q <= dir1_d;
      dir2_q <= dir2_d;
      st1_q  <= st1_d;
      st2_q  <= st2_d;
    end
  end

  assign Dir1_O   = dir1_q;
  assign Dir2_O   = dir2_q;
  assign Start1_O = st1_q;
  assign Start2_O = st2_q;

  // ---------------- coin FSMs ----------------
  logic [1:0] coin_start;
  logic [1:0] coin_n;

  for (genvar gp = 0; gp < 2; gp++) begin : g_coin
    coin_state_t     state_q, state_d;
    logic [CT_W-1:0] cnt_q, cnt_d;
    logic            prev_q;
    logic            level;
    logic            rise;
    logic            start;

    assign level = db[DB_COIN1 + gp];
    // prev_q keeps tracking during Hold_I, so a button held across the end of
    // a hold is not seen as a fresh press.
    assign rise  = level & ~prev_q;

    // Each timed state exits on the cycle after its count reaches the limit,
    // so a zero-length state still lasts exactly one cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start   = 1'b0;
      if (Hold_I) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_d = PULSE;
              cnt_d   = '0;
              start   = 1'b1;
            end
          end
          PULSE: begin
            if (cnt_q == PULSE_LAST) begin
              state_d = GAP;
              cnt_d   = '0;
            end else if (tick) begin
              cnt_d = cnt_q + CT_W'(1);
            end
          end
          GAP: begin
            if (cnt_q == GAP_LAST) begin
              state_d = level ? WAIT_REL : IDLE;
              cnt_d   = '0;
            end else if (tick) begin
              cnt_d = cnt_q + CT_W'(1);
            end
          end
          WAIT_REL: begin
            if (!level) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge Clk_I or negedge Reset_I) begin
      if (!Reset_I) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        prev_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        prev_q  <= level;
      end
    end

    // Decoded straight from the state register so reset releases it at once.
    assign coin_n[gp]     = (state_q != PULSE);
    assign coin_start[gp] = start;
  end

  assign Coin1_O = coin_n[0];
  assign Coin2_O = coin_n[1];

  // ---------------- coin counter ----------------
`ifdef DOMINOS_COIN_COUNTER_EN
  logic [7:0] coin_cnt_q, coin_cnt_d;
  logic [8:0] coin_sum;

  assign coin_sum   = {1'b0, coin_cnt_q} + 9'(coin_start[0]) + 9'(coin_start[1]);
  assign coin_cnt_d = coin_sum[8] ? 8'hFF : coin_sum[7:0];

  always_ff @(posedge Clk_I or negedge Reset_I) begin
    if (!Reset_I) coin_cnt_q <= 8'd0;
    else          coin_cnt_q <= coin_cnt_d;
  end

  assign Coin_Cnt_O = coin_cnt_q;
`else
  logic coin_start_unused;
  assign coin_start_unused = |coin_start;
  assign Coin_Cnt_O        = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dominos_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dominos_input_cond
//  Purpose  : Self-checking bench for dominos_input_cond with a short timebase
//             (TICK_DIV=4, DEBOUNCE_MS=2, COIN_PULSE_MS=3, COIN_GAP_MS=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dominos_input_cond;

  localparam int SETTLE = 16;  // comfortably longer than worst-case debounce

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [15:0] joy0, joy1;
  logic [3:0]  dir1, dir2;
  logic        coin1, coin2, st1, st2;
  logic [7:0]  coin_cnt;

  always #5 clk = ~clk;

  dominos_input_cond #(
    .TICK_DIV      (4),
    .DEBOUNCE_MS   (2),
    .COIN_PULSE_MS (3),
    .COIN_GAP_MS   (2)
  ) dut (
    .Clk_I      (clk),
    .Reset_I    (rst_n),
    .Hold_I     (hold),
    .Joy0_I     (joy0),
    .Joy1_I     (joy1),
    .Dir1_O     (dir1),
    .Dir2_O     (dir2),
    .Coin1_O    (coin1),
    .Coin2_O    (coin2),
    .Start1_O   (st1),
    .Start2_O   (st2),
    .Coin_Cnt_O (coin_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  typedef struct packed {
    logic [3:0] dir1;
    logic [3:0] dir2;
    logic       st1;
    logic       st2;
  } obs_t;

  typedef struct {
    logic [15:0] j0;
    logic [15:0] j1;
    obs_t        want;
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[13];

  // ---------------- coin pulse monitor ----------------
  logic   c1_prev = 1'b1, c2_prev = 1'b1;
  int     c1_falls = 0, c2_falls = 0, c1_run = 0, c1_width = 0;
  longint c1_fall_t = 0, c2_fall_t = 0;

  always @(negedge clk) begin
    if (c1_prev && coin1 === 1'b0) begin c1_falls++; c1_fall_t = $time; end
    if (c2_prev && coin2 === 1'b0) begin c2_falls++; c2_fall_t = $time; end
    if (coin1 === 1'b0) c1_run++;
    else if (!c1_prev) begin c1_width = c1_run; c1_run = 0; end
    c1_prev = (coin1 !== 1'b0);
    c2_prev = (coin2 !== 1'b0);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_coin1_low(input int budget);
    int k = 0;
    while (coin1 !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic add_coins(input int n);
    exp_cnt = (exp_cnt + n > 255) ? 255 : exp_cnt + n;
  endtask

  function automatic logic [7:0] cnt_exp();
`ifdef DOMINOS_COIN_COUNTER_EN
    return exp_cnt[7:0];
`else
    return 8'd0;
`endif
  endfunction

  task automatic check_idle(input string name);
    check({name, "_outs"}, {20'd0, dir1, dir2, coin1, coin2, st1, st2}, 32'hFFF);
    check({name, "_cnt"}, {24'd0, coin_cnt}, {24'd0, cnt_exp()});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   k, f1, f2;
    logic glitch_seen;
    obs_t got, want;

    rst_n = 1'b0; hold = 1'b0; joy0 = '0; joy1 = '0;

    // Stimulus table: directions, cancellation, start merge, unused bits.
    vecs[0]  = '{16'h0000, 16'h0000, '{4'hF, 4'hF, 1'b1, 1'b1}};
    vecs[1]  = '{16'h0008, 16'h0000, '{4'b0111, 4'hF, 1'b1, 1'b1}};
    vecs[2]  = '{16'h000C, 16'h0000, '{4'b1111, 4'hF, 1'b1, 1'b1}};
    vecs[3]  = '{16'h0008, 16'h0000, '{4'b0111, 4'hF, 1'b1, 1'b1}};
    vecs[4]  = '{16'h0003, 16'h0000, '{4'b1111, 4'hF, 1'b1, 1'b1}};
    vecs[5]  = '{16'h0006, 16'h0000, '{4'b1001, 4'hF, 1'b1, 1'b1}};
    vecs[6]  = '{16'h000F, 16'h0000, '{4'b1111, 4'hF, 1'b1, 1'b1}};
    vecs[7]  = '{16'h0000, 16'h0005, '{4'hF, 4'b1010, 1'b1, 1'b1}};
    vecs[8]  = '{16'h0000, 16'h000A, '{4'hF, 4'b0101, 1'b1, 1'b1}};
    vecs[9]  = '{16'h0020, 16'h0000, '{4'hF, 4'hF, 1'b0, 1'b1}};
    vecs[10] = '{16'h0000, 16'h0020, '{4'hF, 4'hF, 1'b0, 1'b1}};
    vecs[11] = '{16'h0040, 16'h0001, '{4'hF, 4'b1110, 1'b1, 1'b0}};
    vecs[12] = '{16'hFF80, 16'hFF80, '{4'hF, 4'hF, 1'b1, 1'b1}};

    // Reset state, then idle after release.
    clocks(3);
    check_idle("reset_state");
    rst_n = 1'b1;
    clocks(10);
    check_idle("idle_after_reset");

    // Debounce latency on Up. The prescaler phase at the press is arbitrary,
    // so acceptance needs between one and two full tick periods after the
    // input register, plus the output register.
    joy0 = 16'h0008;
    k = 0;
    while (dir1[3] !== 1'b0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("dir_latency_window", {31'd0, (k >= 6 && k <= 13)}, 32'd1);
    clocks(20 - k);
    check("dir_up_held", {28'd0, dir1}, 32'h7);
    joy0 = '0;
    clocks(SETTLE);

    // One-tick glitch on Down must never reach the output.
    glitch_seen = 1'b0;
    joy0 = 16'h0004;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 3) joy0 = '0;
      if (dir1[2] === 1'b0) glitch_seen = 1'b1;
    end
    check("glitch_filtered", {31'd0, glitch_seen}, 32'd0);

    // Table-driven directions/starts through the scoreboard queue.
    for (int i = 0; i < 13; i++) begin
      joy0 = vecs[i].j0;
      joy1 = vecs[i].j1;
      sb_q.push_back(vecs[i].want);
      clocks(SETTLE);
      want = sb_q.pop_front();
      got  = '{dir1, dir2, st1, st2};
      check($sformatf("vec%0d", i), {22'd0, got}, {22'd0, want});
    end
    joy0 = '0; joy1 = '0;
    clocks(SETTLE);

    // Coin held for 200 clocks: a single 12-clock pulse.
    f1 = c1_falls;
    joy0 = 16'h0010;
    clocks(200);
    joy0 = '0;
    clocks(30);
    add_coins(1);
    check("coin_held_one_pulse", c1_falls - f1, 32'd1);
    check("coin_pulse_width", c1_width, 32'd12);
    check("coin_high_after", {31'd0, coin1}, 32'd1);
    check("coin_cnt_one", {24'd0, coin_cnt}, {24'd0, cnt_exp()});

    // Release right after the pulse starts and re-press so the debounced
    // second press lands inside PULSE/GAP: it must be dropped.
    f1 = c1_falls;
    joy0 = 16'h0010;
    wait_coin1_low(40);
    check("gap_first_pulse_seen", {31'd0, coin1}, 32'd0);
    joy0 = '0;
    clocks(7);
    joy0 = 16'h0010;
    clocks(60);
    joy0 = '0;
    clocks(30);
    add_coins(1);
    check("gap_press_dropped", c1_falls - f1, 32'd1);
    check("gap_cnt", {24'd0, coin_cnt}, {24'd0, cnt_exp()});

    // Both players in the same cycle.
    f1 = c1_falls; f2 = c2_falls;
    joy0 = 16'h0010; joy1 = 16'h0010;
    clocks(60);
    joy0 = '0; joy1 = '0;
    clocks(30);
    add_coins(2);
    check("simul_p1_pulse", c1_falls - f1, 32'd1);
    check("simul_p2_pulse", c2_falls - f2, 32'd1);
    check("simul_same_cycle", 32'(c2_fall_t), 32'(c1_fall_t));
    check("simul_cnt", {24'd0, coin_cnt}, {24'd0, cnt_exp()});

    // Hold during a pulse, then coin held across the hold release.
    joy0 = 16'h0018;
    wait_coin1_low(40);
    check("hold_pulse_seen", {31'd0, coin1}, 32'd0);
    add_coins(1);
    hold = 1'b1;
    @(negedge clk);
    check_idle("hold_forced");
    clocks(10);
    hold = 1'b0;
    f1 = c1_falls;
    clocks(60);
    check("hold_no_spurious", c1_falls - f1, 32'd0);
    check("hold_dir_back", {28'd0, dir1}, 32'h7);
    joy0 = '0;
    clocks(SETTLE);
    joy0 = 16'h0010;
    clocks(40);
    add_coins(1);
    check("hold_repress", c1_falls - f1, 32'd1);
    joy0 = '0;
    clocks(30);
    check("hold_cnt", {24'd0, coin_cnt}, {24'd0, cnt_exp()});

`ifdef DOMINOS_COIN_COUNTER_EN
    while (exp_cnt < 254) begin
      joy0 = 16'h0010; joy1 = 16'h0010;
      clocks(40);
      joy0 = '0; joy1 = '0;
      clocks(20);
      add_coins(2);
    end
    check("cnt_reach_254", {24'd0, coin_cnt}, {24'd0, cnt_exp()});
    joy0 = 16'h0010; joy1 = 16'h0010;
    clocks(40);
    joy0 = '0; joy1 = '0;
    clocks(20);
    add_coins(2);
    check("cnt_saturate_255", {24'd0, coin_cnt}, 32'd255);
`endif

    // Asynchronous reset in the middle of a pulse.
    joy0 = 16'h0018;
    wait_coin1_low(40);
    check("rst_pulse_seen", {31'd0, coin1}, 32'd0);
    #2 rst_n = 1'b0;
    exp_cnt = 0;
    #1 check_idle("async_reset");
    joy0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    f1 = c1_falls;
    clocks(40);
    check_idle("post_reset_idle");
    check("pulse_not_resumed", c1_falls - f1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
